// File: rtl/encoder_8b10b_pkg.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_pkg
//
// Shared definitions for the 8B/10B transmit sequencer slice:
//   - 8B/10B symbol byte values used by the sequencer (K28.5, K28.0,
//     D21.5, D10.2, D0.0)
//   - the sequencer state enum; its encoding is visible on o_state
//   - a helper that maps a compliance-pattern index to its symbol
// ---------------------------------------------------------------------------
package encoder_8b10b_pkg;

    // Symbol byte values; K symbols are sent with datak=1, D symbols with 0.
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D10_2 = 8'h4A;
    localparam logic [7:0] D0_0  = 8'h00;

    // The encoding doubles as the debug value on o_state.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ALIGN      = 3'd1,
        ST_DATA       = 3'd2,
        ST_SKIP       = 3'd3,
        ST_COMPLIANCE = 3'd4
    } seq_state_t;

    // Compliance pattern {K28.5, D21.5, K28.5, D10.2}.
    // Returns {k_flag, symbol_byte} for pattern position idx.
    function automatic logic [8:0] compliance_symbol(input logic [1:0] idx);
        logic [8:0] sym;
        sym = {1'b1, K28_5};
        case (idx)
            2'd0: sym = {1'b1, K28_5};
            2'd1: sym = {1'b0, D21_5};
            2'd2: sym = {1'b1, K28_5};
            2'd3: sym = {1'b0, D10_2};
            default: sym = {1'b1, K28_5};
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/encoder_8b10b_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_tx_sequencer_if
//
// User-side valid/ready word interface of the transmit sequencer.
//   i_tx_data   user word, byte n in bits [n*8 +: 8]
//   i_tx_datak  per-byte K flag for the user word
//   i_tx_valid  user word valid
//   o_tx_ready  sequencer can accept a word this cycle
// Modports:
//   master  the user logic producing words
//   slave   the sequencer consuming words
// ---------------------------------------------------------------------------
interface encoder_8b10b_tx_sequencer_if #(
    parameter int DATA_BYTES = 2
) ();

    logic [DATA_BYTES*8-1:0] i_tx_data;
    logic [DATA_BYTES-1:0]   i_tx_datak;
    logic                    i_tx_valid;
    logic                    o_tx_ready;

    modport master (
        output i_tx_data,
        output i_tx_datak,
        output i_tx_valid,
        input  o_tx_ready
    );

    modport slave (
        input  i_tx_data,
        input  i_tx_datak,
        input  i_tx_valid,
        output o_tx_ready
    );

endinterface

// File: rtl/encoder_8b10b_compliance_gen.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_compliance_gen
//
// Compliance pattern generator. Byte n of the word carries pattern symbol
// P[(phase + n) mod 4]; phase advances by DATA_BYTES mod 4 per word so the
// pattern streams continuously across words of any width.
//
// Ports:
//   c_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_start   first compliance word: present phase 0 regardless of counter
//   i_run     a compliance word is consumed this cycle; advance phase
//   o_word    pattern word (combinational from phase)
//   o_datak   per-byte K flags of o_word
// ---------------------------------------------------------------------------
module encoder_8b10b_compliance_gen
    import encoder_8b10b_pkg::*;
#(
    parameter int DATA_BYTES = 2
) (
    input  logic                    c_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_run,
    output logic [DATA_BYTES*8-1:0] o_word,
    output logic [DATA_BYTES-1:0]   o_datak
);

    localparam logic [1:0] PHASE_STEP = 2'(DATA_BYTES % 4);

    logic [1:0] phase;
    logic [1:0] eff_phase;

    // A new compliance run always begins at pattern position 0, even if
    // the counter has not yet been cleared.
    assign eff_phase = i_start ? 2'd0 : phase;

    // Per-byte pattern mux; the 2-bit add wraps modulo 4 naturally.
    always_comb begin
        logic [1:0] idx;
        logic [8:0] sym;
        idx     = '0;
        sym     = '0;
        o_word  = '0;
        o_datak = '0;
        for (int n = 0; n < DATA_BYTES; n++) begin
            idx                = eff_phase + n[1:0];
            sym                = compliance_symbol(idx);
            o_word[n*8 +: 8]   = sym[7:0];
            o_datak[n]         = sym[8];
        end
    end

    // Phase counter; parks at 0 whenever the pattern is not being sent.
    always_ff @(posedge c_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= 2'd0;
        end else if (i_run) begin
            phase <= eff_phase + PHASE_STEP;
        end else begin
            phase <= 2'd0;
        end
    end

endmodule

// File: rtl/encoder_8b10b_tx_sequencer.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_tx_sequencer
//
// Drives the inputs of one 8B/10B encoder instance: brings the link up with
// a comma burst, passes user words under valid/ready, fills gaps with idle
// words, inserts periodic skip words and produces the compliance pattern.
//
// Ports:
//   c_clk             clock
//   i_rst_n           asynchronous active-low reset
//   i_link_en         1 = link active, 0 = forced to IDLE
//   i_compliance_req  1 = send compliance pattern
//   tx_if             user word interface (slave side)
//   o_enc_data        to encoder i_data (registered)
//   o_enc_datak       to encoder i_datak (registered)
//   o_enc_enable      to encoder i_enable (registered)
//   o_enc_compliance  to encoder i_compliance (registered)
//   o_state           current state, debug
//   o_aligned         1 while in DATA or SKIP
// ---------------------------------------------------------------------------
module encoder_8b10b_tx_sequencer
    import encoder_8b10b_pkg::*;
#(
    parameter int DATA_BYTES    = 2,
    parameter int ALIGN_WORDS   = 16,
    parameter int SKIP_INTERVAL = 1024,
    parameter int SKIP_WORDS    = 2
) (
    input  logic                         c_clk,
    input  logic                         i_rst_n,
    input  logic                         i_link_en,
    input  logic                         i_compliance_req,
    encoder_8b10b_tx_sequencer_if.slave  tx_if,
    output logic [DATA_BYTES*8-1:0]      o_enc_data,
    output logic [DATA_BYTES-1:0]        o_enc_datak,
    output logic                         o_enc_enable,
    output logic                         o_enc_compliance,
    output logic [2:0]                   o_state,
    output logic                         o_aligned
);

    localparam int DW      = DATA_BYTES * 8;
    localparam int ALIGN_W = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
    localparam int SKIP_W  = $clog2(SKIP_INTERVAL);
    localparam int SKIPW_W = (SKIP_WORDS > 1) ? $clog2(SKIP_WORDS) : 1;

    localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_WORDS - 1);
    localparam logic [SKIP_W-1:0]  SKIP_LAST  = SKIP_W'(SKIP_INTERVAL - 1);
    localparam logic [SKIPW_W-1:0] SKIPW_LAST = SKIPW_W'(SKIP_WORDS - 1);

    // Idle word: K28.5 in byte 0, D0.0 (zero) in the rest, so a
    // zero-extended K28.5 is exactly the idle word.
    localparam logic [DW-1:0]         IDLE_WORD  = DW'(K28_5);
    localparam logic [DATA_BYTES-1:0] IDLE_DATAK = DATA_BYTES'(1);
    localparam logic [DW-1:0]         ALIGN_WORD = {DATA_BYTES{K28_5}};
    localparam logic [DW-1:0]         SKIP_WORD  = {DATA_BYTES{K28_0}};
    localparam logic [DATA_BYTES-1:0] ALL_K      = '1;

    seq_state_t              state, state_nxt;
    logic [ALIGN_W-1:0]      align_cnt, align_nxt;
    logic [SKIP_W-1:0]       skip_cnt, skip_nxt;
    logic [SKIPW_W-1:0]      skipw_cnt, skipw_nxt;

    logic [DW-1:0]           data_nxt;
    logic [DATA_BYTES-1:0]   datak_nxt;
    logic                    enable_nxt;
    logic                    compl_nxt;

    logic                    gen_start;
    logic                    gen_run;
    logic [DW-1:0]           gen_word;
    logic [DATA_BYTES-1:0]   gen_datak;

    logic                    tx_ready;
    logic                    handshake;

    encoder_8b10b_compliance_gen #(
        .DATA_BYTES (DATA_BYTES)
    ) u_compliance_gen (
        .c_clk   (c_clk),
        .i_rst_n (i_rst_n),
        .i_start (gen_start),
        .i_run   (gen_run),
        .o_word  (gen_word),
        .o_datak (gen_datak)
    );

    // Ready depends on registered state only. The cycle just before a skip
    // insertion is blocked so that an idle word can precede the skip burst.
    // A word offered while link_en drops or compliance is requested in the
    // same cycle is acknowledged but not transmitted.
    assign tx_ready         = (state == ST_DATA) && (skip_cnt != SKIP_LAST);
    assign handshake        = tx_ready && tx_if.i_tx_valid;
    assign tx_if.o_tx_ready = tx_ready;

    assign o_state   = state;
    assign o_aligned = (state == ST_DATA) || (state == ST_SKIP);

    // Next-state and next-output-word logic. The word chosen here is loaded
    // into the output registers at the same edge as the state change, so
    // aborting to IDLE zeroes the encoder inputs immediately.
    always_comb begin
        state_nxt  = state;
        align_nxt  = align_cnt;
        skip_nxt   = skip_cnt;
        skipw_nxt  = skipw_cnt;
        data_nxt   = '0;
        datak_nxt  = '0;
        enable_nxt = 1'b0;
        compl_nxt  = 1'b0;
        gen_start  = 1'b0;
        gen_run    = 1'b0;

        if (!i_link_en) begin
            state_nxt = ST_IDLE;
            align_nxt = '0;
            skip_nxt  = '0;
            skipw_nxt = '0;
        end else if (i_compliance_req) begin
            // Only the first word of a run flags compliance to the encoder,
            // forcing that word to start at negative disparity.
            state_nxt  = ST_COMPLIANCE;
            gen_start  = (state != ST_COMPLIANCE);
            gen_run    = 1'b1;
            data_nxt   = gen_word;
            datak_nxt  = gen_datak;
            enable_nxt = 1'b1;
            compl_nxt  = gen_start;
            align_nxt  = '0;
            skip_nxt   = '0;
            skipw_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ALIGN;
                    align_nxt = '0;
                end
                ST_ALIGN: begin
                    data_nxt   = ALIGN_WORD;
                    datak_nxt  = ALL_K;
                    enable_nxt = 1'b1;
                    if (align_cnt == ALIGN_LAST) begin
                        state_nxt = ST_DATA;
                        align_nxt = '0;
                        skip_nxt  = '0;
                    end else begin
                        align_nxt = align_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    enable_nxt = 1'b1;
                    if (skip_cnt == SKIP_LAST) begin
                        data_nxt  = IDLE_WORD;
                        datak_nxt = IDLE_DATAK;
                        state_nxt = ST_SKIP;
                        skip_nxt  = '0;
                        skipw_nxt = '0;
                    end else begin
                        skip_nxt = skip_cnt + 1'b1;
                        if (handshake) begin
                            data_nxt  = tx_if.i_tx_data;
                            datak_nxt = tx_if.i_tx_datak;
                        end else begin
                            data_nxt  = IDLE_WORD;
                            datak_nxt = IDLE_DATAK;
                        end
                    end
                end
                ST_SKIP: begin
                    data_nxt   = SKIP_WORD;
                    datak_nxt  = ALL_K;
                    enable_nxt = 1'b1;
                    if (skipw_cnt == SKIPW_LAST) begin
                        state_nxt = ST_DATA;
                        skipw_nxt = '0;
                    end else begin
                        skipw_nxt = skipw_cnt + 1'b1;
                    end
                end
                ST_COMPLIANCE: begin
                    // Request withdrawn: keep the link busy with an idle
                    // word while heading back to re-alignment.
                    data_nxt   = IDLE_WORD;
                    datak_nxt  = IDLE_DATAK;
                    enable_nxt = 1'b1;
                    state_nxt  = ST_ALIGN;
                    align_nxt  = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered encoder inputs.
    always_ff @(posedge c_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            align_cnt        <= '0;
            skip_cnt         <= '0;
            skipw_cnt        <= '0;
            o_enc_data       <= '0;
            o_enc_datak      <= '0;
            o_enc_enable     <= 1'b0;
            o_enc_compliance <= 1'b0;
        end else begin
            state            <= state_nxt;
            align_cnt        <= align_nxt;
            skip_cnt         <= skip_nxt;
            skipw_cnt        <= skipw_nxt;
            o_enc_data       <= data_nxt;
            o_enc_datak      <= datak_nxt;
            o_enc_enable     <= enable_nxt;
            o_enc_compliance <= compl_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_8b10b_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_encoder_8b10b_tx_sequencer
//
// Self-checking bench for encoder_8b10b_tx_sequencer with DATA_BYTES=2,
// ALIGN_WORDS=4, SKIP_INTERVAL=8, SKIP_WORDS=2. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_encoder_8b10b_tx_sequencer;

    localparam int DB     = 2;
    localparam int AW     = 4;
    localparam int SI     = 8;
    localparam int SW     = 2;
    localparam int PERIOD = SI + SW;

    localparam logic [15:0] ALIGN_WORD = 16'hBCBC;
    localparam logic [15:0] IDLE_WORD  = 16'h00BC;
    localparam logic [15:0] SKIP_WORD  = 16'h1C1C;

    logic        c_clk = 1'b0;
    logic        i_rst_n;
    logic        i_link_en;
    logic        i_compliance_req;
    logic [15:0] o_enc_data;
    logic [1:0]  o_enc_datak;
    logic        o_enc_enable;
    logic        o_enc_compliance;
    logic [2:0]  o_state;
    logic        o_aligned;

    int compared   = 0;
    int mismatched = 0;

    encoder_8b10b_tx_sequencer_if #(.DATA_BYTES(DB)) tx_if ();

    encoder_8b10b_tx_sequencer #(
        .DATA_BYTES    (DB),
        .ALIGN_WORDS   (AW),
        .SKIP_INTERVAL (SI),
        .SKIP_WORDS    (SW)
    ) dut (
        .c_clk            (c_clk),
        .i_rst_n          (i_rst_n),
        .i_link_en        (i_link_en),
        .i_compliance_req (i_compliance_req),
        .tx_if            (tx_if),
        .o_enc_data       (o_enc_data),
        .o_enc_datak      (o_enc_datak),
        .o_enc_enable     (o_enc_enable),
        .o_enc_compliance (o_enc_compliance),
        .o_state          (o_state),
        .o_aligned        (o_aligned)
    );

    // 10 ns clock
    always #5 c_clk = ~c_clk;

    // Reference model for one cycle of the aligned phase. q counts cycles
    // since DATA was entered; the link repeats a fixed period of SI-1 ready
    // cycles, one idle cycle, then SW skip cycles.
    function automatic void model_data_cycle(
        input  int          q,
        input  logic        valid,
        input  logic [15:0] d,
        input  logic [1:0]  k,
        output logic        exp_ready,
        output logic [2:0]  exp_state,
        output logic [15:0] exp_d,
        output logic [1:0]  exp_k
    );
        int pos;
        pos       = q % PERIOD;
        exp_ready = (pos < SI - 1);
        exp_state = (pos < SI) ? 3'd2 : 3'd3;
        if (pos >= SI) begin
            exp_d = SKIP_WORD;
            exp_k = 2'b11;
        end else if (exp_ready && valid) begin
            exp_d = d;
            exp_k = k;
        end else begin
            exp_d = IDLE_WORD;
            exp_k = 2'b01;
        end
    endfunction

    // Returns the link to IDLE, re-enables it and waits through the comma
    // burst so that the caller starts in the first DATA cycle.
    task automatic bring_up();
        i_link_en        = 1'b0;
        i_compliance_req = 1'b0;
        tx_if.i_tx_valid = 1'b0;
        @(negedge c_clk);
        i_link_en = 1'b1;
        repeat (1 + AW) @(negedge c_clk);
    endtask

    // Everything at zero while reset is held.
    task automatic test_reset();
        i_rst_n          = 1'b0;
        i_link_en        = 1'b0;
        i_compliance_req = 1'b0;
        tx_if.i_tx_valid = 1'b0;
        tx_if.i_tx_data  = '0;
        tx_if.i_tx_datak = '0;
        repeat (3) @(negedge c_clk);
        compared++;
        if (o_enc_data !== 16'h0 || o_enc_datak !== 2'b00 || o_enc_enable !== 1'b0 ||
            o_enc_compliance !== 1'b0 || tx_if.o_tx_ready !== 1'b0 ||
            o_state !== 3'd0 || o_aligned !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_values data=%h datak=%b en=%b comp=%b rdy=%b st=%0d al=%b expected all zero",
                     o_enc_data, o_enc_datak, o_enc_enable, o_enc_compliance,
                     tx_if.o_tx_ready, o_state, o_aligned);
        end
        i_rst_n = 1'b1;
        @(negedge c_clk);
    endtask

    // Comma burst of AW words followed by an idle word.
    task automatic test_align();
        i_link_en        = 1'b0;
        tx_if.i_tx_valid = 1'b0;
        @(negedge c_clk);
        i_link_en = 1'b1;
        @(negedge c_clk);
        compared++;
        if (o_state !== 3'd1 || o_enc_enable !== 1'b0 || o_enc_data !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL align_entry st=%0d en=%b data=%h expected st=1 en=0 data=0000",
                     o_state, o_enc_enable, o_enc_data);
        end
        for (int i = 0; i < AW; i++) begin
            @(negedge c_clk);
            compared++;
            if (o_enc_data !== ALIGN_WORD || o_enc_datak !== 2'b11 || o_enc_enable !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL align_word%0d data=%h datak=%b en=%b expected data=%h datak=11 en=1",
                         i, o_enc_data, o_enc_datak, o_enc_enable, ALIGN_WORD);
            end
        end
        compared++;
        if (o_state !== 3'd2 || o_aligned !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL align_done st=%0d al=%b expected st=2 al=1", o_state, o_aligned);
        end
        @(negedge c_clk);
        compared++;
        if (o_enc_data !== IDLE_WORD || o_enc_datak !== 2'b01 || o_aligned !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL align_idle data=%h datak=%b al=%b expected data=%h datak=01 al=1",
                     o_enc_data, o_enc_datak, o_aligned, IDLE_WORD);
        end
    endtask

    // A single accepted word appears one cycle later; dropping valid
    // brings back the idle word.
    task automatic test_handshake();
        bring_up();
        compared++;
        if (tx_if.o_tx_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hs_ready rdy=%b expected 1", tx_if.o_tx_ready);
        end
        tx_if.i_tx_valid = 1'b1;
        tx_if.i_tx_data  = 16'h1234;
        tx_if.i_tx_datak = 2'b00;
        @(negedge c_clk);
        compared++;
        if (o_enc_data !== 16'h1234 || o_enc_datak !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL hs_word data=%h datak=%b expected data=1234 datak=00",
                     o_enc_data, o_enc_datak);
        end
        tx_if.i_tx_valid = 1'b0;
        @(negedge c_clk);
        compared++;
        if (o_enc_data !== IDLE_WORD || o_enc_datak !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL hs_idle data=%h datak=%b expected data=%h datak=01",
                     o_enc_data, o_enc_datak, IDLE_WORD);
        end
    endtask

    // Valid held high: three full skip periods, every cycle checked against
    // the model, and the number of accepted words counted per period.
    task automatic test_skip_period();
        logic        er;
        logic [2:0]  es;
        logic [15:0] ed, d;
        logic [1:0]  ek;
        int          accepted;
        accepted = 0;
        bring_up();
        for (int q = 0; q < 3 * PERIOD; q++) begin
            d = 16'($urandom);
            model_data_cycle(q, 1'b1, d, 2'b00, er, es, ed, ek);
            compared++;
            if (tx_if.o_tx_ready !== er || o_state !== es || o_aligned !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL skip_ctrl q=%0d rdy=%b st=%0d al=%b expected rdy=%b st=%0d al=1",
                         q, tx_if.o_tx_ready, o_state, o_aligned, er, es);
            end
            if (tx_if.o_tx_ready === 1'b1) accepted++;
            tx_if.i_tx_valid = 1'b1;
            tx_if.i_tx_data  = d;
            tx_if.i_tx_datak = 2'b00;
            @(negedge c_clk);
            compared++;
            if (o_enc_data !== ed || o_enc_datak !== ek || o_enc_enable !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL skip_word q=%0d data=%h datak=%b en=%b expected data=%h datak=%b en=1",
                         q, o_enc_data, o_enc_datak, o_enc_enable, ed, ek);
            end
        end
        tx_if.i_tx_valid = 1'b0;
        compared++;
        if (accepted != 3 * (SI - 1)) begin
            mismatched++;
            $display("[TB] FAIL skip_accept_count got=%0d expected=%0d", accepted, 3 * (SI - 1));
        end
    endtask

    // Random valid, data and K flags through several skip periods.
    task automatic test_random_traffic();
        logic        er, v;
        logic [2:0]  es;
        logic [15:0] ed, d;
        logic [1:0]  ek, k;
        bring_up();
        for (int q = 0; q < 45; q++) begin
            v = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            k = 2'($urandom_range(0, 3));
            model_data_cycle(q, v, d, k, er, es, ed, ek);
            compared++;
            if (tx_if.o_tx_ready !== er || o_state !== es) begin
                mismatched++;
                $display("[TB] FAIL rand_ctrl q=%0d rdy=%b st=%0d expected rdy=%b st=%0d",
                         q, tx_if.o_tx_ready, o_state, er, es);
            end
            tx_if.i_tx_valid = v;
            tx_if.i_tx_data  = d;
            tx_if.i_tx_datak = k;
            @(negedge c_clk);
            compared++;
            if (o_enc_data !== ed || o_enc_datak !== ek) begin
                mismatched++;
                $display("[TB] FAIL rand_word q=%0d data=%h datak=%b expected data=%h datak=%b",
                         q, o_enc_data, o_enc_datak, ed, ek);
            end
        end
        tx_if.i_tx_valid = 1'b0;
    endtask

    // Compliance pattern from DATA, then re-alignment when withdrawn.
    task automatic test_compliance();
        logic [7:0]  pat  [4];
        logic        patk [4];
        logic [15:0] ed;
        logic [1:0]  ek;
        pat[0] = 8'hBC; pat[1] = 8'hB5; pat[2] = 8'hBC; pat[3] = 8'h4A;
        patk[0] = 1'b1; patk[1] = 1'b0; patk[2] = 1'b1; patk[3] = 1'b0;
        bring_up();
        repeat (3) @(negedge c_clk);
        i_compliance_req = 1'b1;
        for (int w = 0; w < 6; w++) begin
            @(negedge c_clk);
            ed = {pat[(w * DB + 1) % 4], pat[(w * DB) % 4]};
            ek = {patk[(w * DB + 1) % 4], patk[(w * DB) % 4]};
            compared++;
            if (o_enc_data !== ed || o_enc_datak !== ek || o_enc_enable !== 1'b1 ||
                o_enc_compliance !== (w == 0) || tx_if.o_tx_ready !== 1'b0 || o_state !== 3'd4) begin
                mismatched++;
                $display("[TB] FAIL compl_word%0d data=%h datak=%b en=%b comp=%b rdy=%b st=%0d expected data=%h datak=%b en=1 comp=%b rdy=0 st=4",
                         w, o_enc_data, o_enc_datak, o_enc_enable, o_enc_compliance,
                         tx_if.o_tx_ready, o_state, ed, ek, (w == 0));
            end
        end
        i_compliance_req = 1'b0;
        @(negedge c_clk);
        compared++;
        if (o_state !== 3'd1 || tx_if.o_tx_ready !== 1'b0 || o_enc_compliance !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL compl_exit st=%0d rdy=%b comp=%b expected st=1 rdy=0 comp=0",
                     o_state, tx_if.o_tx_ready, o_enc_compliance);
        end
        for (int i = 0; i < AW; i++) begin
            @(negedge c_clk);
            compared++;
            if (o_enc_data !== ALIGN_WORD || o_enc_datak !== 2'b11) begin
                mismatched++;
                $display("[TB] FAIL compl_realign%0d data=%h datak=%b expected data=%h datak=11",
                         i, o_enc_data, o_enc_datak, ALIGN_WORD);
            end
        end
        compared++;
        if (o_state !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL compl_back_to_data st=%0d expected 2", o_state);
        end
    endtask

    // Link disabled during a skip burst, then re-enabled.
    task automatic test_link_drop();
        bring_up();
        repeat (SI) @(negedge c_clk);
        compared++;
        if (o_state !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL drop_in_skip st=%0d expected 3", o_state);
        end
        i_link_en = 1'b0;
        @(negedge c_clk);
        compared++;
        if (o_enc_enable !== 1'b0 || o_enc_data !== 16'h0 || o_enc_datak !== 2'b00 ||
            tx_if.o_tx_ready !== 1'b0 || o_state !== 3'd0 || o_aligned !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drop_idle en=%b data=%h datak=%b rdy=%b st=%0d al=%b expected all zero",
                     o_enc_enable, o_enc_data, o_enc_datak, tx_if.o_tx_ready, o_state, o_aligned);
        end
        i_link_en = 1'b1;
        @(negedge c_clk);
        compared++;
        if (o_state !== 3'd1 || o_enc_enable !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drop_realign_entry st=%0d en=%b expected st=1 en=0", o_state, o_enc_enable);
        end
        for (int i = 0; i < AW; i++) begin
            @(negedge c_clk);
            compared++;
            if (o_enc_data !== ALIGN_WORD || o_enc_datak !== 2'b11 || o_enc_enable !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL drop_realign%0d data=%h datak=%b en=%b expected data=%h datak=11 en=1",
                         i, o_enc_data, o_enc_datak, o_enc_enable, ALIGN_WORD);
            end
        end
        @(negedge c_clk);
        compared++;
        if (o_enc_data !== IDLE_WORD || o_enc_datak !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL drop_idle_after data=%h datak=%b expected data=%h datak=01",
                     o_enc_data, o_enc_datak, IDLE_WORD);
        end
    endtask

    // Reset asserted between clock edges while user words flow.
    task automatic test_async_reset();
        bring_up();
        tx_if.i_tx_valid = 1'b1;
        tx_if.i_tx_datak = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tx_if.i_tx_data = 16'($urandom) | 16'h0100;
            @(negedge c_clk);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        compared++;
        if (o_enc_data !== 16'h0 || o_enc_datak !== 2'b00 || o_enc_enable !== 1'b0 ||
            o_enc_compliance !== 1'b0 || tx_if.o_tx_ready !== 1'b0 ||
            o_state !== 3'd0 || o_aligned !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset data=%h datak=%b en=%b comp=%b rdy=%b st=%0d al=%b expected all zero",
                     o_enc_data, o_enc_datak, o_enc_enable, o_enc_compliance,
                     tx_if.o_tx_ready, o_state, o_aligned);
        end
        tx_if.i_tx_valid = 1'b0;
        @(negedge c_clk);
        i_rst_n = 1'b1;
        #1;
        compared++;
        if (o_state !== 3'd0 || o_enc_enable !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_release st=%0d en=%b expected st=0 en=0", o_state, o_enc_enable);
        end
        @(negedge c_clk);
        compared++;
        if (o_state !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL async_restart st=%0d expected 1", o_state);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_align();
        test_handshake();
        test_skip_period();
        test_random_traffic();
        test_compliance();
        test_link_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/encoder_8b10b_tx_sequencer.md
Name: encoder_8b10b_tx_sequencer

Overview:
- Sequences the 8B/10B encoder for one transmit link, driving its i_data, i_datak, i_enable and i_compliance inputs.
- Brings the link up with a comma alignment burst, then passes user words under a valid/ready handshake.
- Inserts idle words when the user has no data, and inserts periodic skip (clock-compensation) words.
- Generates the compliance pattern on request.

Parameters:
- DATA_BYTES, 2, bytes per word; must match the encoder instance.
- ALIGN_WORDS, 16, number of all-comma words sent in ALIGN (>=1).
- SKIP_INTERVAL, 1024, DATA-state cycles between skip insertions (>=2).
- SKIP_WORDS, 2, skip words per insertion (>=1).

Ports:
- c_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_link_en  in  1  1 = link active; 0 = IDLE.
- i_compliance_req  in  1  1 = send compliance pattern.
- i_tx_data  in  DATA_BYTES*8  user word; byte n is bits [n*8+:8].
- i_tx_datak  in  DATA_BYTES  per-byte K flag for the user word.
- i_tx_valid  in  1  user word valid.
- o_tx_ready  out  1  word accepted when i_tx_valid && o_tx_ready.
- o_enc_data  out  DATA_BYTES*8  to encoder i_data.
- o_enc_datak  out  DATA_BYTES  to encoder i_datak.
- o_enc_enable  out  1  to encoder i_enable.
- o_enc_compliance  out  1  to encoder i_compliance.
- o_state  out  3  current FSM state, for debug.
- o_aligned  out  1  1 while in DATA or SKIP.

Behaviour:
- Reset: all o_enc_* outputs 0, state IDLE, all counters 0, compliance phase 0, o_tx_ready 0, o_aligned 0.
- Register boundary:
  - All o_enc_* outputs are registered; an accepted word appears on o_enc_data one cycle after acceptance.
  - o_tx_ready decodes from registers only; there is no combinational path from i_tx_valid.
- Symbols:
  - K28.5 = 8'hBC, k=1. K28.0 = 8'h1C, k=1.
  - D21.5 = 8'hB5, k=0. D10.2 = 8'h4A, k=0. D0.0 = 8'h00, k=0.
  - Idle word: byte0 = K28.5; other bytes = D0.0.
- State priority, evaluated every cycle, highest first:
  - i_link_en=0 goes to IDLE from any state. This abandons ALIGN, SKIP or COMPLIANCE mid-sequence.
  - Otherwise, i_compliance_req=1 goes to COMPLIANCE.
- IDLE:
  - Outputs load 0 with o_enc_enable=0.
  - Goes to ALIGN when i_link_en=1 and i_compliance_req=0.
- ALIGN:
  - Loads all bytes with K28.5 (datak all 1) for ALIGN_WORDS cycles.
  - Then goes to DATA; skip_cnt clears on entry.
- DATA:
  - o_tx_ready=1 except when skip_cnt==SKIP_INTERVAL-1.
  - On a handshake, load the user word. With no valid, or with ready=0, load the idle word.
  - skip_cnt increments every DATA cycle.
  - At SKIP_INTERVAL-1: an idle word is loaded, state goes to SKIP, skip_cnt clears.
- SKIP:
  - o_tx_ready=0.
  - Loads all bytes with K28.0 (datak all 1) for SKIP_WORDS cycles, then returns to DATA.
- COMPLIANCE:
  - o_tx_ready=0.
  - Pattern P = {K28.5, D21.5, K28.5, D10.2}.
  - Byte n loads P[(phase+n) mod 4]; phase advances by DATA_BYTES mod 4 each cycle.
  - Phase is 0 on entry.
  - o_enc_compliance is 1 on the first COMPLIANCE word only, so that word starts at negative disparity.
  - When i_compliance_req=0 (with link_en=1), go to ALIGN.
- o_enc_enable=1 in every state except IDLE.
- o_state encoding: IDLE=0, ALIGN=1, DATA=2, SKIP=3, COMPLIANCE=4.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Decomposition:
- Package encoder_8b10b_pkg holds:
  - the symbol constants (K28_5, K28_0, D21_5, D10_2, D0_0);
  - the state enum (3-bit) with the encoding above.
- One sub-module, encoder_8b10b_compliance_gen, holds the phase counter and per-byte pattern mux.
  - Inputs: c_clk, i_rst_n, i_start, i_run.
  - Outputs: word and datak.

Test Plan:
- Reset, then i_link_en=1, ALIGN_WORDS=4, DATA_BYTES=2 -> o_enc_enable rises. Four words of 16'hBCBC, datak 2'b11, then the idle word 16'h00BC, datak 2'b01; o_aligned=1.
- DATA with i_tx_valid=1, data 16'h1234, datak 0 -> o_tx_ready=1; o_enc_data=16'h1234 exactly one cycle after acceptance. Drop valid -> 16'h00BC the next cycle.
- SKIP_INTERVAL=8, SKIP_WORDS=2, valid held high -> repeating 10-cycle period:
  - 7 accepted words;
  - 1 idle word, with ready low;
  - 2 words of 16'h1C1C, datak 2'b11.
- i_compliance_req=1 from DATA -> output alternates 16'hB5BC (datak 01) and 16'h4ABC (datak 01). o_enc_compliance=1 on the first word only. Deassert -> ALIGN burst.
- i_link_en=0 mid-SKIP -> IDLE next cycle: o_enc_enable=0, outputs 0, o_tx_ready=0. Re-enable -> full ALIGN burst.
- Assert i_rst_n=0 asynchronously mid-DATA -> all outputs 0 without waiting for a clock edge. Release -> IDLE.
